spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) that terminates the SPI master links of soc_core (MSI/MSO/SSn/SCLK). It lives in the test/peripheral domain on HCLK. It oversamples the pad-level SCLK/SSn/MOSI through synchronisers and shifts data in both directions. Byte-wide TX and RX FIFOs use valid/ready handshakes toward local logic.

Parameters:
DEPTH, 4, entries per FIFO (TX and RX); power of two, minimum 2
SYNC_STAGES, 2, synchroniser flops on SCLK, SSn and MOSI; minimum 2

Ports:
HCLK  input  1  system clock; all logic on rising edge
HRESETn  input  1  synchronous active-low reset
SCLK  input  1  SPI clock from master, asynchronous to HCLK
SSn  input  1  active-low slave select from master
MOSI  input  1  master-out data (master's MSO)
MISO  output  1  slave-out data (master's MSI)
MISO_oeb  output  1  pad output-enable for MISO, active low
tx_data  input  8  byte to return to master
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX FIFO not full
rx_data  output  8  received byte, RX FIFO head
rx_valid  output  1  RX FIFO not empty
rx_ready  input  1  consumer pops RX head
tx_underrun  output  1  sticky: byte sent while TX FIFO empty
rx_overrun  output  1  sticky: byte dropped because RX FIFO full
clr_err  input  1  clears both sticky flags
busy  output  1  SSn (synchronised) low

Behaviour:
- Reset (HRESETn=0 at an HCLK edge): both FIFOs empty, synchronisers load idle values (SCLK=0, SSn=1, MOSI=0), state IDLE, bit count 0, MISO=0, MISO_oeb=1, tx_ready=1, rx_valid=0, rx_data=0, both flags 0, busy=0. Reset mid-frame aborts the frame with no FIFO write.
- Synchronisers: SYNC_STAGES flops per input. Edge detect compares the last synchronised sample with the previous one. Supported SCLK frequency is at most HCLK/8.
- States:
  - IDLE: MISO_oeb=1. A synchronised SSn falling edge moves to SHIFT.
  - SHIFT: active while SSn is low. A synchronised SSn rising edge returns to IDLE from any bit count. A partial byte is discarded with no RX push, and the current TX byte is lost (it was already popped).
- Entering SHIFT:
  - Pop the TX FIFO head into the tx shift register, or load 0x00 and set tx_underrun if the FIFO is empty.
  - MISO = bit7; MISO_oeb=0 on the same cycle; bit count=0.
- SCLK rising edge (synchronised): shift MOSI into the rx shift register LSB; bit count+1.
  - On the 8th rise, push the assembled byte to the RX FIFO and reset bit count to 0.
  - If the RX FIFO is full and rx_ready=0 on that cycle, drop the byte and set rx_overrun.
  - If full with rx_ready=1, pop and push happen together and the byte is accepted.
- SCLK falling edge (synchronised): shift tx left; MISO = next bit.
  - After the 8th fall of a byte, load the next byte using the same pop/underrun rule, so a back-to-back frame needs no SSn toggle.
- Latency: MISO changes SYNC_STAGES+1 HCLK cycles after the pad SCLK falling edge. rx_valid rises at most SYNC_STAGES+2 cycles after the 8th pad SCLK rise.
- FIFOs:
  - Push/pop pointers are log2(DEPTH) bits and wrap naturally; occupancy count is log2(DEPTH)+1 bits.
  - TX push occurs when tx_valid&tx_ready. A simultaneous push and internal pop at any occupancy is legal, with count unchanged.
  - rx_data is combinational from the head entry and is 0x00 when the FIFO is empty.
- Sticky flags: set by their events, cleared by clr_err. If set and clear coincide, set wins.
- busy mirrors ~SSn_sync.

Test Plan:
- Preload TX 0xA5. Master sends 0x3C in one SSn-low frame at HCLK/8 → MISO bits 1,0,1,0,0,1,0,1 sampled on SCLK rises; rx_data=0x3C, rx_valid=1; MISO_oeb returns to 1 after SSn rises; no flags set.
- Preload TX 0x11,0x22. Master sends 0x81,0x42 back-to-back in one frame → master receives 0x11,0x22; RX FIFO holds 0x81 then 0x42.
- TX FIFO empty. One byte exchanged → MISO all zeros; tx_underrun=1 until clr_err pulse, then 0.
- DEPTH=4, rx_ready=0. Master sends 5 bytes 0x01..0x05 → FIFO holds 0x01..0x04; rx_overrun=1. Repeat with rx_ready=1 pulsed on the 5th byte's push cycle → 0x05 accepted and no overrun.
- SSn deasserted after 5 SCLK rises, then a full byte 0x7E is sent → only 0x7E appears in RX; state back in IDLE between frames.
- Assert HRESETn=0 mid-byte (bit 4) → all outputs at reset values next cycle; RX FIFO empty; subsequent frame works normally.

Source files
------------

// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit frames) running entirely
// on HCLK. The pad-level SCLK/SSn/MOSI are brought in through SYNC_STAGES-deep
// synchronisers, and edges are detected on the synchronised copies. Received
// bytes go to an RX FIFO and transmitted bytes come from a TX FIFO. Both FIFOs
// use valid/ready handshakes toward local logic.
//
// Ports:
//   HCLK, HRESETn      system clock, synchronous active-low reset
//   SCLK, SSn, MOSI    SPI pad inputs from the master (asynchronous)
//   MISO, MISO_oeb     SPI data to the master, pad output-enable (active low)
//   tx_data/valid/ready  byte stream into the TX FIFO
//   rx_data/valid/ready  byte stream out of the RX FIFO (rx_data is 0 when empty)
//   tx_underrun        sticky: a byte was sent while the TX FIFO was empty
//   rx_overrun         sticky: a received byte was dropped on a full RX FIFO
//   clr_err            clears both sticky flags (a coincident set wins)
//   busy               synchronised slave select is active
// -----------------------------------------------------------------------------
module spi_slave_responder #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       SCLK,
  input  logic       SSn,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_oeb,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_underrun,
  output logic       rx_overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ssn_sync_q,  ssn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ssn_prev_q,  ssn_prev_d;

  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic                   miso_oeb_q, miso_oeb_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   rx_overrun_q, rx_overrun_d;

  logic [7:0]             tx_mem_q [DEPTH];
  logic [7:0]             tx_mem_d [DEPTH];
  logic [PW-1:0]          tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PW-1:0]          tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0]          tx_count_q, tx_count_d;

  logic [7:0]             rx_mem_q [DEPTH];
  logic [7:0]             rx_mem_d [DEPTH];
  logic [PW-1:0]          rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PW-1:0]          rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]          rx_count_q, rx_count_d;

  logic sclk_s, ssn_s, mosi_s;
  logic sclk_rise, sclk_fall, ssn_rise, ssn_fall;
  logic tx_empty, tx_push, tx_pop, tx_load;
  logic rx_full, rx_push, rx_pop, rx_push_req;
  logic [7:0] tx_head, rx_byte;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ssn_s  = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ssn_rise  = ssn_s & ~ssn_prev_q;
  assign ssn_fall  = ~ssn_s & ssn_prev_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0],  SSn};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    ssn_prev_d  = ssn_s;
  end

  // ---------------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------------
  assign tx_empty = (tx_count_q == '0);
  assign tx_ready = (tx_count_q != FULL);
  assign tx_head  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = tx_load & ~tx_empty;

  assign rx_full  = (rx_count_q == FULL);
  assign rx_valid = (rx_count_q != '0);
  assign rx_data  = rx_valid ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
  assign rx_pop   = rx_ready & rx_valid;
  // A full FIFO still accepts the byte when the consumer pops on the same cycle.
  assign rx_push  = rx_push_req & (~rx_full | rx_ready);
  assign rx_byte  = {rx_shift_q, mosi_s};

  // ---------------------------------------------------------------------------
  // Frame state machine and shift registers
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_oeb_d  = miso_oeb_q;
    tx_load     = 1'b0;
    rx_push_req = 1'b0;

    case (state_q)
      IDLE: begin
        miso_oeb_d = 1'b1;
        if (ssn_fall) begin
          state_d    = SHIFT;
          bit_cnt_d  = 3'd0;
          miso_oeb_d = 1'b0;
          tx_load    = 1'b1;
        end
      end

      SHIFT: begin
        if (ssn_rise) begin
          // Abort: partial RX byte is discarded, current TX byte is lost.
          state_d    = IDLE;
          bit_cnt_d  = 3'd0;
          miso_oeb_d = 1'b1;
          tx_shift_d = 8'h00;
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d   = 3'd0;
            rx_push_req = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sclk_fall) begin
          // SCLK idles low, so a fall seen with the count at zero can only
          // follow the 8th rise: the byte is finished, fetch the next one.
          if (bit_cnt_q == 3'd0) begin
            tx_load = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (tx_load) begin
      tx_shift_d = tx_head;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, storage and sticky flags
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q + CW'(tx_push) - CW'(tx_pop);
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = tx_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + PW'(1);
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
    end

    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q + CW'(rx_push) - CW'(rx_pop);
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = rx_byte;
      rx_wr_ptr_d           = rx_wr_ptr_q + PW'(1);
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
    end

    tx_underrun_d = (tx_load & tx_empty) | (tx_underrun_q & ~clr_err);
    rx_overrun_d  = (rx_push_req & rx_full & ~rx_ready) | (rx_overrun_q & ~clr_err);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sclk_sync_q   <= '0;
      ssn_sync_q    <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      ssn_prev_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 8'h00;
      miso_oeb_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_count_q    <= '0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_count_q    <= '0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      ssn_sync_q    <= ssn_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      ssn_prev_q    <= ssn_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      miso_oeb_q    <= miso_oeb_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_count_q    <= tx_count_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_count_q    <= rx_count_d;
    end
  end

  // NOTE: FIFO storage has no reset; the counts guard every read, and rx_data
  // is forced to zero while the FIFO is empty.
  always_ff @(posedge HCLK) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign MISO        = tx_shift_q[7];
  assign MISO_oeb    = miso_oeb_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_overrun  = rx_overrun_q;
  assign busy        = ~ssn_s;

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
//
// Directed bench for spi_slave_responder (DEPTH=4, SYNC_STAGES=2). Acts as a
// mode-0 SPI master with SCLK = HCLK/8, changing pad signals on HCLK falling
// edges and sampling DUT outputs on falling edges as well.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       SCLK, SSn, MOSI;
  logic       MISO, MISO_oeb;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       tx_underrun, rx_overrun, clr_err, busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] got;

  spi_slave_responder #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .SCLK        (SCLK),
    .SSn         (SSn),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .MISO_oeb    (MISO_oeb),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_underrun (tx_underrun),
    .rx_overrun  (rx_overrun),
    .clr_err     (clr_err),
    .busy        (busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {7'd0, obs}, {7'd0, exp});
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge HCLK);
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_bit({tag, "_valid"}, rx_valid, 1'b1);
    check(tag, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge HCLK);
    rx_ready = 1'b0;
  endtask

  task automatic frame_start();
    SSn = 1'b0;
    repeat (4) @(negedge HCLK);
  endtask

  // Shifts nbits of b (MSB first); got collects MISO as sampled on each rise.
  // end_frame raises SSn after the last rise, before SCLK returns low.
  // pulse raises rx_ready for the single cycle on which the 8th rise pushes.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit end_frame,
                          input bit pulse, output logic [7:0] got_o);
    got_o = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[7-i];
      repeat (4) @(negedge HCLK);
      got_o[7-i] = MISO;
      SCLK = 1'b1;
      repeat (2) @(negedge HCLK);
      if (pulse && i == 7) rx_ready = 1'b1;
      @(negedge HCLK);
      if (pulse && i == 7) rx_ready = 1'b0;
      @(negedge HCLK);
      if (end_frame && i == nbits - 1) begin
        SSn = 1'b1;
        @(negedge HCLK);
      end
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge HCLK);
  endtask

  initial begin
    HRESETn  = 1'b0;
    SCLK     = 1'b0;
    SSn      = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(negedge HCLK);

    // Reset state
    check_bit("rst_miso", MISO, 1'b0);
    check_bit("rst_oeb", MISO_oeb, 1'b1);
    check_bit("rst_tx_ready", tx_ready, 1'b1);
    check_bit("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check_bit("rst_busy", busy, 1'b0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Single byte: return 0xA5, receive 0x3C
    push_tx(8'hA5);
    frame_start();
    check_bit("t1_busy", busy, 1'b1);
    check_bit("t1_oeb_low", MISO_oeb, 1'b0);
    spi_bits(8'h3C, 8, 1'b1, 1'b0, got);
    check("t1_master_rx", got, 8'hA5);
    settle();
    check_bit("t1_oeb_high", MISO_oeb, 1'b1);
    check_bit("t1_busy_idle", busy, 1'b0);
    check_bit("t1_underrun", tx_underrun, 1'b0);
    check_bit("t1_overrun", rx_overrun, 1'b0);
    pop_check("t1_rx", 8'h3C);
    check_bit("t1_rx_empty", rx_valid, 1'b0);
    check("t1_rx_data_empty", rx_data, 8'h00);

    // Back-to-back bytes in one frame
    push_tx(8'h11);
    push_tx(8'h22);
    frame_start();
    spi_bits(8'h81, 8, 1'b0, 1'b0, got);
    check("t2_master_rx0", got, 8'h11);
    spi_bits(8'h42, 8, 1'b1, 1'b0, got);
    check("t2_master_rx1", got, 8'h22);
    settle();
    pop_check("t2_rx0", 8'h81);
    pop_check("t2_rx1", 8'h42);
    check_bit("t2_rx_empty", rx_valid, 1'b0);
    check_bit("t2_underrun", tx_underrun, 1'b0);

    // Empty TX FIFO: zeros out, underrun until cleared
    frame_start();
    spi_bits(8'h5A, 8, 1'b1, 1'b0, got);
    check("t3_master_rx", got, 8'h00);
    settle();
    check_bit("t3_underrun_set", tx_underrun, 1'b1);
    pop_check("t3_rx", 8'h5A);
    check_bit("t3_underrun_held", tx_underrun, 1'b1);
    clr_err = 1'b1;
    @(negedge HCLK);
    clr_err = 1'b0;
    check_bit("t3_underrun_clr", tx_underrun, 1'b0);

    // Overrun: five bytes into a four-deep FIFO with no consumer
    frame_start();
    for (int k = 1; k <= 5; k++) begin
      spi_bits(8'(k), 8, k == 5, 1'b0, got);
    end
    settle();
    check_bit("t4a_overrun", rx_overrun, 1'b1);
    pop_check("t4a_rx0", 8'h01);
    pop_check("t4a_rx1", 8'h02);
    pop_check("t4a_rx2", 8'h03);
    pop_check("t4a_rx3", 8'h04);
    check_bit("t4a_rx_empty", rx_valid, 1'b0);
    clr_err = 1'b1;
    @(negedge HCLK);
    clr_err = 1'b0;
    check_bit("t4a_overrun_clr", rx_overrun, 1'b0);

    // Same, with a pop coinciding with the 5th push
    frame_start();
    for (int k = 1; k <= 5; k++) begin
      spi_bits(8'(k), 8, k == 5, k == 5, got);
    end
    settle();
    check_bit("t4b_overrun", rx_overrun, 1'b0);
    pop_check("t4b_rx0", 8'h02);
    pop_check("t4b_rx1", 8'h03);
    pop_check("t4b_rx2", 8'h04);
    pop_check("t4b_rx3", 8'h05);
    check_bit("t4b_rx_empty", rx_valid, 1'b0);
    clr_err = 1'b1;
    @(negedge HCLK);
    clr_err = 1'b0;

    // Partial frame discarded, then a full byte
    frame_start();
    spi_bits(8'hFF, 5, 1'b1, 1'b0, got);
    settle();
    check_bit("t5_idle_oeb", MISO_oeb, 1'b1);
    check_bit("t5_idle_busy", busy, 1'b0);
    check_bit("t5_no_partial", rx_valid, 1'b0);
    frame_start();
    spi_bits(8'h7E, 8, 1'b1, 1'b0, got);
    settle();
    pop_check("t5_rx", 8'h7E);
    check_bit("t5_rx_empty", rx_valid, 1'b0);
    clr_err = 1'b1;
    @(negedge HCLK);
    clr_err = 1'b0;

    // Reset in the middle of a byte
    push_tx(8'hAA);
    push_tx(8'hBB);
    push_tx(8'hCC);
    push_tx(8'hDD);
    check_bit("t6_tx_full", tx_ready, 1'b0);
    frame_start();
    spi_bits(8'h5A, 8, 1'b0, 1'b0, got);
    check("t6_master_rx0", got, 8'hAA);
    spi_bits(8'h00, 4, 1'b0, 1'b0, got);
    check_bit("t6_rx_before", rx_valid, 1'b1);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check_bit("t6_rst_miso", MISO, 1'b0);
    check_bit("t6_rst_oeb", MISO_oeb, 1'b1);
    check_bit("t6_rst_tx_ready", tx_ready, 1'b1);
    check_bit("t6_rst_rx_valid", rx_valid, 1'b0);
    check("t6_rst_rx_data", rx_data, 8'h00);
    check_bit("t6_rst_underrun", tx_underrun, 1'b0);
    check_bit("t6_rst_overrun", rx_overrun, 1'b0);
    check_bit("t6_rst_busy", busy, 1'b0);
    SSn = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    push_tx(8'hC3);
    frame_start();
    spi_bits(8'h96, 8, 1'b1, 1'b0, got);
    check("t6_master_rx", got, 8'hC3);
    settle();
    pop_check("t6_rx", 8'h96);
    check_bit("t6_rx_empty", rx_valid, 1'b0);
    check_bit("t6_underrun", tx_underrun, 1'b0);
    check_bit("t6_overrun", rx_overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
